// File: rtl/sig_phase_sched.sv
// Timed phase scheduler for a highway / country-road intersection.
// Walks the two signal heads through green, yellow and all-red clearance
// phases using per-phase cycle counts, latches car and pedestrian requests,
// holds a minimum highway green, caps country green, and drives the
// highway crosswalk walk lamp.
module sig_phase_sched #(
  parameter int unsigned MIN_HWY_GRN   = 8,
  parameter int unsigned YEL_CYC       = 3,
  parameter int unsigned ALLRED_CYC    = 2,
  parameter int unsigned MAX_CNTRY_GRN = 6,
  parameter int unsigned WALK_CYC      = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       car_req,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  // Phase encoding (highway head / country head).
  localparam logic [2:0] S0 = 3'd0;  // GREEN  / RED
  localparam logic [2:0] S1 = 3'd1;  // YELLOW / RED
  localparam logic [2:0] S2 = 3'd2;  // RED    / RED   (clearance to country)
  localparam logic [2:0] S3 = 3'd3;  // RED    / GREEN
  localparam logic [2:0] S4 = 3'd4;  // RED    / YELLOW
  localparam logic [2:0] S5 = 3'd5;  // RED    / RED   (clearance to highway)

  // Signal head colour encoding.
  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;

  // Counter value seen in the last cycle of each timed phase.
  localparam logic [CNT_W-1:0] MIN_HWY_LAST   = CNT_W'(MIN_HWY_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST       = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_CNTRY_LAST = CNT_W'(MAX_CNTRY_GRN - 1);
  localparam logic [CNT_W-1:0] WALK_LAST      = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_CNT       = CNT_W'(WALK_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX        = '1;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_car_pend;
  logic             r_ped_pend;
  logic             r_walk_act;
  logic             r_ped_ack;

  logic [2:0]       w_next_state;
  logic             w_any;
  logic [CNT_W-1:0] w_minc_last;
  logic             w_phase_change;
  logic             w_s2_to_s3;
  logic             w_s5_to_s0;

  // Live requests count alongside the latched ones so a request arriving on
  // the deciding edge is not delayed by a cycle.
  assign w_any = r_car_pend | r_ped_pend | car_req | ped_req;

  // A served pedestrian stretches the country green to cover the walk time.
  assign w_minc_last = r_walk_act ? WALK_LAST : '0;

  // Next-phase decision from the current phase and its elapsed count.
  always_comb begin
    // NOTE: next state defaults to the current one so every path through the
    // case assigns it and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S0: if ((r_cnt >= MIN_HWY_LAST) && w_any)       w_next_state = S1;
      S1: if (r_cnt == YEL_LAST)                      w_next_state = S2;
      S2: if (r_cnt == ALLRED_LAST)                   w_next_state = S3;
      S3: if ((r_cnt >= w_minc_last) &&
              (!car_req || (r_cnt == MAX_CNTRY_LAST))) w_next_state = S4;
      S4: if (r_cnt == YEL_LAST)                      w_next_state = S5;
      S5: if (r_cnt == ALLRED_LAST)                   w_next_state = S0;
      default:                                        w_next_state = S0;
    endcase
  end

  assign w_phase_change = (w_next_state != r_state);
  assign w_s2_to_s3     = (r_state == S2) && (w_next_state == S3);
  assign w_s5_to_s0     = (r_state == S5) && (w_next_state == S0);

  // Phase register and its elapsed-cycle counter (saturating).
  always_ff @(posedge clock) begin
    // NOTE: registers update with non-blocking assignments so every block
    // sees the pre-edge values regardless of evaluation order.
    if (clear) begin
      r_state <= S0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_phase_change)      r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Request latches; consumed when the country green begins unless the
  // request is still being asserted on that very edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_car_pend <= 1'b0;
      r_ped_pend <= 1'b0;
    end else if (w_s2_to_s3) begin
      r_car_pend <= car_req;
      r_ped_pend <= ped_req;
    end else begin
      r_car_pend <= r_car_pend | car_req;
      r_ped_pend <= r_ped_pend | ped_req;
    end
  end

  // Pedestrian service flag for the current country phase and its ack pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_walk_act <= 1'b0;
      r_ped_ack  <= 1'b0;
    end else begin
      r_ped_ack <= w_s2_to_s3 & (r_ped_pend | ped_req);
      if (w_s2_to_s3)      r_walk_act <= r_ped_pend | ped_req;
      else if (w_s5_to_s0) r_walk_act <= 1'b0;
    end
  end

  // Head colours decoded from the phase register only; illegal codes show
  // RED on both roads until recovery on the next edge.
  always_comb begin
    hwy   = RED;
    cntry = RED;
    case (r_state)
      S0:      hwy   = GRN;
      S1:      hwy   = YEL;
      S3:      cntry = GRN;
      S4:      cntry = YEL;
      default: begin
        hwy   = RED;
        cntry = RED;
      end
    endcase
  end

  assign walk    = (r_state == S3) & r_walk_act & (r_cnt < WALK_CNT);
  assign ped_ack = r_ped_ack;
  assign state_o = r_state;

endmodule

// File: tb/tb_sig_phase_sched.sv
// Self-checking bench for sig_phase_sched: directed scenarios with
// hand-derived phase timings plus a long randomized run compared each cycle
// against a phase/age reference model.
module tb_sig_phase_sched;

  localparam int MIN_HWY_GRN   = 8;
  localparam int YEL_CYC       = 3;
  localparam int ALLRED_CYC    = 2;
  localparam int MAX_CNTRY_GRN = 6;
  localparam int WALK_CYC      = 4;
  localparam int CNT_W         = 8;

  logic       clock;
  logic       clear;
  logic       car_req;
  logic       ped_req;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  sig_phase_sched #(
    .MIN_HWY_GRN  (MIN_HWY_GRN),
    .YEL_CYC      (YEL_CYC),
    .ALLRED_CYC   (ALLRED_CYC),
    .MAX_CNTRY_GRN(MAX_CNTRY_GRN),
    .WALK_CYC     (WALK_CYC),
    .CNT_W        (CNT_W)
  ) dut (
    .clock  (clock),
    .clear  (clear),
    .car_req(car_req),
    .ped_req(ped_req),
    .hwy    (hwy),
    .cntry  (cntry),
    .walk   (walk),
    .ped_ack(ped_ack),
    .state_o(state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: phase index plus an unbounded age within the phase.
  int m_phase;
  int m_age;
  bit m_car;
  bit m_ped;
  bit m_walk_act;
  bit m_ack;

  // Per-cycle trace of DUT outputs, sampled 1 time unit after each edge.
  logic [2:0] q_state[$];
  logic [1:0] q_hwy[$];
  logic [1:0] q_cntry[$];
  logic       q_walk[$];
  logic       q_ack[$];
  int         run_val[$];
  int         run_len[$];

  function automatic logic [1:0] exp_hwy(int p);
    case (p)
      0:       return 2'd2;
      1:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_cntry(int p);
    case (p)
      3:       return 2'd2;
      4:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic bit exp_walk();
    return (m_phase == 3) && m_walk_act && (m_age < WALK_CYC);
  endfunction

  // Drive one cycle of inputs, advance the model by the phase rules, take
  // the clock edge and record the resulting DUT outputs.
  task automatic tick(input bit car, input bit ped, input bit clr);
    bit adv;
    int minc;
    car_req = car;
    ped_req = ped;
    clear   = clr;
    adv     = 1'b0;
    if (clr) begin
      m_phase = 0; m_age = 0; m_car = 0; m_ped = 0; m_walk_act = 0; m_ack = 0;
    end else begin
      case (m_phase)
        0: adv = (m_age >= MIN_HWY_GRN - 1) && (m_car || m_ped || car || ped);
        1: adv = (m_age >= YEL_CYC - 1);
        2: adv = (m_age >= ALLRED_CYC - 1);
        3: begin
          minc = m_walk_act ? WALK_CYC : 1;
          adv  = (m_age >= minc - 1) && (!car || (m_age >= MAX_CNTRY_GRN - 1));
        end
        4: adv = (m_age >= YEL_CYC - 1);
        default: adv = (m_age >= ALLRED_CYC - 1);
      endcase
      if (m_phase == 2 && adv) begin
        m_walk_act = m_ped | ped;
        m_ack      = m_ped | ped;
        m_car      = car;
        m_ped      = ped;
      end else begin
        m_ack = 1'b0;
        m_car = m_car | car;
        m_ped = m_ped | ped;
        if (m_phase == 5 && adv) m_walk_act = 1'b0;
      end
      if (adv) begin
        m_phase = (m_phase + 1) % 6;
        m_age   = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
    @(posedge clock);
    #1;
    q_state.push_back(state_o);
    q_hwy.push_back(hwy);
    q_cntry.push_back(cntry);
    q_walk.push_back(walk);
    q_ack.push_back(ped_ack);
  endtask

  task automatic do_reset();
    q_state.delete(); q_hwy.delete(); q_cntry.delete();
    q_walk.delete(); q_ack.delete();
    tick(1'b0, 1'b0, 1'b1);
  endtask

  function automatic void build_runs();
    run_val.delete();
    run_len.delete();
    foreach (q_state[i]) begin
      if (i == 0 || q_state[i] != q_state[i-1]) begin
        run_val.push_back(int'(q_state[i]));
        run_len.push_back(1);
      end else begin
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
      end
    end
  endfunction

  task automatic test_reset();
    tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (hwy !== 2'd2)     begin errors++; $display("FAIL reset_hwy: got %0d expected 2", hwy); end
    checks++; if (cntry !== 2'd0)   begin errors++; $display("FAIL reset_cntry: got %0d expected 0", cntry); end
    checks++; if (walk !== 1'b0)    begin errors++; $display("FAIL reset_walk: got %0d expected 0", walk); end
    checks++; if (ped_ack !== 1'b0) begin errors++; $display("FAIL reset_ped_ack: got %0d expected 0", ped_ack); end
  endtask

  task automatic test_car_pulse();
    int exp_val[7] = '{0, 1, 2, 3, 4, 5, 0};
    int exp_len[7] = '{8, 3, 2, 1, 3, 2, 25};
    int walk_hi = 0;
    do_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (40) tick(0, 0, 0);
    build_runs();
    checks++;
    if (run_val.size() != 7) begin
      errors++; $display("FAIL car_pulse_runs: got %0d phases expected 7", run_val.size());
    end
    for (int i = 0; i < 7 && i < run_val.size(); i++) begin
      checks++;
      if (run_val[i] != exp_val[i] || run_len[i] != exp_len[i]) begin
        errors++;
        $display("FAIL car_pulse_phase%0d: got S%0d x%0d expected S%0d x%0d",
                 i, run_val[i], run_len[i], exp_val[i], exp_len[i]);
      end
    end
    foreach (q_walk[i]) if (q_walk[i] !== 1'b0) walk_hi++;
    checks++; if (walk_hi != 0) begin errors++; $display("FAIL car_pulse_walk: got %0d lit cycles expected 0", walk_hi); end
  endtask

  task automatic test_car_held();
    int exp_len[6] = '{8, 3, 2, 6, 3, 2};
    int s3_runs = 0;
    int unsafe  = 0;
    do_reset();
    repeat (80) tick(1, 0, 0);
    build_runs();
    for (int i = 0; i + 1 < run_val.size(); i++) begin
      if (run_val[i] == 3) s3_runs++;
      checks++;
      if (run_val[i] != (i % 6) || run_len[i] != exp_len[i % 6]) begin
        errors++;
        $display("FAIL car_held_phase%0d: got S%0d x%0d expected S%0d x%0d",
                 i, run_val[i], run_len[i], i % 6, exp_len[i % 6]);
      end
    end
    checks++; if (s3_runs != 3) begin errors++; $display("FAIL car_held_s3_count: got %0d expected 3", s3_runs); end
    foreach (q_hwy[i]) if (q_hwy[i] != 2'd0 && q_cntry[i] != 2'd0) unsafe++;
    checks++; if (unsafe != 0) begin errors++; $display("FAIL car_held_safety: got %0d conflicting cycles expected 0", unsafe); end
  endtask

  task automatic test_ped_pulse();
    int exp_val[7] = '{0, 1, 2, 3, 4, 5, 0};
    int exp_len[7] = '{8, 3, 2, 4, 3, 2, 10};
    do_reset();
    tick(0, 1, 0);
    repeat (30) tick(0, 0, 0);
    build_runs();
    checks++;
    if (run_val.size() != 7) begin
      errors++; $display("FAIL ped_pulse_runs: got %0d phases expected 7", run_val.size());
    end
    for (int i = 0; i < 7 && i < run_val.size(); i++) begin
      checks++;
      if (run_val[i] != exp_val[i] || run_len[i] != exp_len[i]) begin
        errors++;
        $display("FAIL ped_pulse_phase%0d: got S%0d x%0d expected S%0d x%0d",
                 i, run_val[i], run_len[i], exp_val[i], exp_len[i]);
      end
    end
    foreach (q_walk[i]) begin
      checks++;
      if (q_walk[i] !== 1'((i >= 13) && (i <= 16)) || q_ack[i] !== 1'(i == 13)) begin
        errors++;
        $display("FAIL ped_pulse_lamp@%0d: got walk=%0d ack=%0d expected walk=%0d ack=%0d",
                 i, q_walk[i], q_ack[i], (i >= 13) && (i <= 16), i == 13);
      end
    end
  endtask

  task automatic test_clear_mid();
    int moved = 0;
    do_reset();
    repeat (13) tick(1, 1, 0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    checks++;
    if (state_o !== 3'd3 || walk !== 1'b1) begin
      errors++; $display("FAIL clear_mid_pre: got S%0d walk=%0d expected S3 walk=1", state_o, walk);
    end
    tick(1, 1, 1);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL clear_mid_state: got %0d expected 0", state_o); end
    checks++; if (hwy !== 2'd2 || cntry !== 2'd0) begin
      errors++; $display("FAIL clear_mid_heads: got %0d/%0d expected 2/0", hwy, cntry);
    end
    checks++; if (walk !== 1'b0 || ped_ack !== 1'b0) begin
      errors++; $display("FAIL clear_mid_lamp: got walk=%0d ack=%0d expected 0/0", walk, ped_ack);
    end
    repeat (30) begin
      tick(0, 0, 0);
      if (state_o !== 3'd0 || hwy !== 2'd2) moved++;
    end
    checks++; if (moved != 0) begin errors++; $display("FAIL clear_mid_hold: got %0d non-S0 cycles expected 0", moved); end
  endtask

  task automatic test_sat_path();
    int idle[4] = '{20, 7, 259, 6};
    logic [2:0] want;
    foreach (idle[k]) begin
      do_reset();
      repeat (idle[k]) tick(0, 0, 0);
      tick(1, 0, 0);
      want = (idle[k] >= MIN_HWY_GRN - 1) ? 3'd1 : 3'd0;
      checks++;
      if (state_o !== want) begin
        errors++; $display("FAIL sat_path_cnt%0d: got S%0d expected S%0d", idle[k], state_o, want);
      end
      if (want == 3'd0) begin
        tick(0, 0, 0);
        checks++;
        if (state_o !== 3'd1) begin
          errors++; $display("FAIL sat_path_late%0d: got S%0d expected S1", idle[k], state_o);
        end
      end
    end
  endtask

  task automatic test_ped_in_car_cycle();
    do_reset();
    tick(1, 0, 0);
    repeat (11) tick(0, 0, 0);
    tick(0, 0, 0);
    checks++;
    if (state_o !== 3'd3 || walk !== 1'b0) begin
      errors++; $display("FAIL ped_late_s3: got S%0d walk=%0d expected S3 walk=0", state_o, walk);
    end
    tick(0, 1, 0);
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL ped_late_exit: got S%0d expected S4", state_o); end
    repeat (40) tick(0, 0, 0);
    checks++;
    if (q_state[32] !== 3'd3 || q_state[36] !== 3'd4) begin
      errors++; $display("FAIL ped_late_s3_span: got S%0d..S%0d expected S3..S4", q_state[32], q_state[36]);
    end
    foreach (q_walk[i]) begin
      checks++;
      if (q_walk[i] !== 1'((i >= 32) && (i <= 35)) || q_ack[i] !== 1'(i == 32)) begin
        errors++;
        $display("FAIL ped_late_lamp@%0d: got walk=%0d ack=%0d expected walk=%0d ack=%0d",
                 i, q_walk[i], q_ack[i], (i >= 32) && (i <= 35), i == 32);
      end
    end
  endtask

  task automatic test_random();
    int car_pct = 50;
    bit car, ped, clr;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       car_pct = 3;
          1:       car_pct = 50;
          default: car_pct = 97;
        endcase
      end
      car = ($urandom_range(0, 99) < car_pct);
      ped = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 499) == 0);
      tick(car, ped, clr);
      checks++;
      if (state_o !== 3'(m_phase) || hwy !== exp_hwy(m_phase) || cntry !== exp_cntry(m_phase)) begin
        errors++;
        $display("FAIL random_phase@%0d: got S%0d %0d/%0d expected S%0d %0d/%0d",
                 n, state_o, hwy, cntry, m_phase, exp_hwy(m_phase), exp_cntry(m_phase));
      end
      checks++;
      if (walk !== exp_walk() || ped_ack !== m_ack) begin
        errors++;
        $display("FAIL random_lamp@%0d: got walk=%0d ack=%0d expected walk=%0d ack=%0d",
                 n, walk, ped_ack, exp_walk(), m_ack);
      end
      checks++;
      if (hwy != 2'd0 && cntry != 2'd0) begin
        errors++; $display("FAIL random_safety@%0d: got %0d/%0d expected one head RED", n, hwy, cntry);
      end
    end
  endtask

  initial begin
    clear   = 1'b1;
    car_req = 1'b0;
    ped_req = 1'b0;
    test_reset();
    test_car_pulse();
    test_car_held();
    test_ped_pulse();
    test_clear_mid();
    test_sat_path();
    test_ped_in_car_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
